// File: rtl/mem_responder_if.sv
// CPU <-> memory responder bus: async-SRAM style strobes, MMIO switches and HEX display.
interface mem_responder_if;
  logic [15:0] Addr;
  logic [15:0] Data_from_CPU;
  logic        Mem_CE;
  logic        Mem_OE;
  logic        Mem_WE;
  logic        Mem_UB;
  logic        Mem_LB;
  logic [15:0] Switches;
  logic [15:0] Data_to_CPU;
  logic [15:0] HEX_out;
  logic        Busy;
  logic        Err;
  logic [15:0] Acc_count;

  modport master (
    output Addr, Data_from_CPU, Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB, Switches,
    input  Data_to_CPU, HEX_out, Busy, Err, Acc_count
  );
  modport slave (
    input  Addr, Data_from_CPU, Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB, Switches,
    output Data_to_CPU, HEX_out, Busy, Err, Acc_count
  );
endinterface

// File: rtl/mem_responder.sv
// Word memory plus one MMIO word behind an active-low strobe bus; writes need the
// strobe held two cycles, reads return registered data one cycle after OE is sampled.
module mem_responder #(
  parameter int          ADDR_BITS = 8,
  parameter logic [15:0] IO_ADDR   = 16'hFFFF
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  mem_responder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RD, WR1, WR_DONE} state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_mem [0:(1<<ADDR_BITS)-1];
  logic [15:0] r_rdata, r_hex, r_cnt;
  logic        r_err;

  logic        w_rd, w_wr, w_both, w_is_io;
  logic        w_load, w_commit, w_err_set, w_cnt_inc;
  logic [15:0] w_rdata;
  logic [ADDR_BITS-1:0] w_idx;

  assign w_rd    = !bus.Mem_CE && !bus.Mem_OE &&  bus.Mem_WE;
  assign w_wr    = !bus.Mem_CE &&  bus.Mem_OE && !bus.Mem_WE;
  assign w_both  = !bus.Mem_CE && !bus.Mem_OE && !bus.Mem_WE;
  assign w_is_io = (bus.Addr == IO_ADDR);
  assign w_idx   = bus.Addr[ADDR_BITS-1:0];
  assign w_rdata = w_is_io ? bus.Switches : r_mem[w_idx];

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_commit    = 1'b0;
    w_err_set   = 1'b0;
    w_cnt_inc   = 1'b0;
    if (bus.Mem_CE) begin
      w_state_nxt = IDLE;
      w_err_set   = (r_state == WR1);
    end else if (w_both) begin
      w_state_nxt = IDLE;
      w_err_set   = 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_rd) begin
            w_state_nxt = RD;
            w_load      = 1'b1;
            w_cnt_inc   = 1'b1;
          end else if (w_wr) begin
            w_state_nxt = WR1;
          end
        end
        RD: begin
          if (w_rd) w_load      = 1'b1;
          else      w_state_nxt = IDLE;
        end
        WR1: begin
          if (w_wr) begin
            w_state_nxt = WR_DONE;
            w_commit    = 1'b1;
            w_cnt_inc   = 1'b1;
          end else begin
            w_state_nxt = IDLE;
            w_err_set   = 1'b1;
          end
        end
        WR_DONE: if (bus.Mem_WE) w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Storage is deliberately left out of reset; a commit can only happen from WR1,
  // which reset clears asynchronously, so an interrupted write never lands.
  always_ff @(posedge i_clk)
    if (w_commit && !w_is_io) begin
      if (!bus.Mem_UB) r_mem[w_idx][15:8] <= bus.Data_from_CPU[15:8];
      if (!bus.Mem_LB) r_mem[w_idx][7:0]  <= bus.Data_from_CPU[7:0];
    end

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_rdata <= '0;
      r_hex   <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_load) r_rdata <= w_rdata;
      if (w_commit && w_is_io) begin
        if (!bus.Mem_UB) r_hex[15:8] <= bus.Data_from_CPU[15:8];
        if (!bus.Mem_LB) r_hex[7:0]  <= bus.Data_from_CPU[7:0];
      end
      if (w_cnt_inc && r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
      if (w_err_set) r_err <= 1'b1;
    end

  assign bus.Data_to_CPU = r_rdata;
  assign bus.HEX_out     = r_hex;
  assign bus.Acc_count   = r_cnt;
  assign bus.Err         = r_err;
  assign bus.Busy        = (r_state != IDLE);
endmodule

// File: tb/tb_mem_responder.sv
// Random transaction-level stimulus for mem_responder, checked against a word-array model.
module tb_mem_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_responder_if bus();
  mem_responder dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

  int total = 0;
  int bad   = 0;

  logic [15:0] m_mem [0:255];
  logic [15:0] m_hex, m_data;
  logic        m_err;
  int          m_cnt;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw,
                                        input logic ub, input logic lb);
    merge = old;
    if (!ub) merge[15:8] = nw[15:8];
    if (!lb) merge[7:0]  = nw[7:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    bus.Mem_CE = 1'b1; bus.Mem_OE = 1'b1; bus.Mem_WE = 1'b1;
    bus.Mem_UB = 1'b1; bus.Mem_LB = 1'b1;
  endtask

  task automatic chk_status(input string tag);
    chk({tag, ".err"},  {15'd0, bus.Err}, {15'd0, m_err});
    chk({tag, ".cnt"},  bus.Acc_count, (m_cnt > 65535) ? 16'hFFFF : m_cnt[15:0]);
    chk({tag, ".hex"},  bus.HEX_out, m_hex);
    chk({tag, ".busy"}, {15'd0, bus.Busy}, 16'd0);
    chk({tag, ".data"}, bus.Data_to_CPU, m_data);
  endtask

  task automatic do_reset();
    bus_idle();
    rst_n = 1'b0;
    #2;
    m_hex = '0; m_data = '0; m_err = 1'b0; m_cnt = 0;
    chk_status("rst");
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d, input logic ub,
                    input logic lb, input int len);
    bus.Addr = a; bus.Data_from_CPU = d; bus.Mem_UB = ub; bus.Mem_LB = lb;
    bus.Mem_CE = 1'b0; bus.Mem_OE = 1'b1; bus.Mem_WE = 1'b0;
    for (int i = 0; i < len; i++) begin
      tick();
      if (i == 1) begin
        if (a == 16'hFFFF) m_hex = merge(m_hex, d, ub, lb);
        else m_mem[a[7:0]] = merge(m_mem[a[7:0]], d, ub, lb);
        m_cnt++;
        chk("wr.hex_commit", bus.HEX_out, m_hex);
      end
      chk("wr.busy", {15'd0, bus.Busy}, 16'd1);
    end
    if (len < 2) m_err = 1'b1;
    bus_idle();
    tick();
  endtask

  task automatic rd(input logic [15:0] a, input logic [15:0] sw, input int len);
    bus.Addr = a; bus.Switches = sw;
    bus.Mem_CE = 1'b0; bus.Mem_OE = 1'b0; bus.Mem_WE = 1'b1;
    bus.Mem_UB = $urandom_range(0, 1); bus.Mem_LB = $urandom_range(0, 1);
    tick();
    m_data = (a == 16'hFFFF) ? sw : m_mem[a[7:0]];
    m_cnt++;
    chk("rd.data", bus.Data_to_CPU, m_data);
    for (int i = 1; i < len; i++) tick();
    bus_idle();
    tick();
    chk("rd.hold", bus.Data_to_CPU, m_data);
  endtask

  task automatic both_err();
    bus.Mem_CE = 1'b0; bus.Mem_OE = 1'b0; bus.Mem_WE = 1'b0;
    tick();
    m_err = 1'b1;
    chk("both.busy", {15'd0, bus.Busy}, 16'd0);
    bus_idle();
    tick();
  endtask

  logic [15:0] a, d, saved;

  initial begin
    bus_idle();
    bus.Addr = '0; bus.Data_from_CPU = '0; bus.Switches = '0;
    #12;
    do_reset();

    for (int i = 0; i < 256; i++) wr(16'(i), 16'($urandom), 1'b0, 1'b0, 2);
    chk_status("init");

    do_reset();
    wr(16'h0012, 16'hBEEF, 1'b0, 1'b0, 2);
    rd(16'h0012, 16'h0000, 2);
    chk("wr_rd.data", bus.Data_to_CPU, 16'hBEEF);
    chk("wr_rd.cnt", bus.Acc_count, 16'd2);
    chk("wr_rd.err", {15'd0, bus.Err}, 16'd0);

    wr(16'h0003, 16'h1234, 1'b0, 1'b0, 2);
    wr(16'h0003, 16'hABCD, 1'b1, 1'b0, 2);
    rd(16'h0003, 16'h0000, 2);
    chk("lane.data", bus.Data_to_CPU, 16'h12CD);

    rd(16'hFFFF, 16'h00A5, 2);
    chk("mmio.rd", bus.Data_to_CPU, 16'h00A5);
    saved = m_mem[8'hFF];
    wr(16'hFFFF, 16'h0042, 1'b0, 1'b0, 2);
    chk("mmio.hex", bus.HEX_out, 16'h0042);
    rd(16'h00FF, 16'h0000, 2);
    chk("mmio.noalias", bus.Data_to_CPU, saved);
    chk_status("mmio");

    do_reset();
    saved = m_mem[7];
    wr(16'h0007, ~saved, 1'b0, 1'b0, 1);
    chk("short.err", {15'd0, bus.Err}, 16'd1);
    chk("short.cnt", bus.Acc_count, 16'd0);
    rd(16'h0007, 16'h0000, 1);
    chk("short.mem", bus.Data_to_CPU, saved);

    do_reset();
    both_err();
    chk_status("both");

    do_reset();
    saved = m_mem[7];
    bus.Addr = 16'h0007; bus.Data_from_CPU = ~saved; bus.Mem_UB = 1'b0; bus.Mem_LB = 1'b0;
    bus.Mem_CE = 1'b0; bus.Mem_OE = 1'b1; bus.Mem_WE = 1'b0;
    tick();
    chk("midrst.wr1", {15'd0, bus.Busy}, 16'd1);
    wr(16'hFFFF, 16'h5A5A, 1'b0, 1'b0, 0);
    do_reset();
    rd(16'h0007, 16'h0000, 2);
    chk("midrst.mem", bus.Data_to_CPU, saved);
    chk_status("midrst");

    wr(16'h0040, 16'h0F0F, 1'b0, 1'b0, 5);
    chk_status("long");
    wr(16'h0112, 16'hC0DE, 1'b0, 1'b0, 2);
    rd(16'h0012, 16'h0000, 2);
    chk("alias.data", bus.Data_to_CPU, 16'hC0DE);

    for (int n = 0; n < 400; n++) begin
      int kind;
      kind = $urandom_range(0, 19);
      a = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      d = 16'($urandom);
      if (kind < 8)
        wr(a, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 5) == 0) ? 1 : $urandom_range(2, 5));
      else if (kind < 16) rd(a, d, $urandom_range(1, 4));
      else if (kind < 18) both_err();
      else if (kind == 18) do_reset();
      else begin bus_idle(); tick(); end
      chk_status("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_BITS, default 8: number of low address bits that index internal word storage (2^ADDR_BITS x 16 words).
REQ-002 Parameter IO_ADDR, default 16'hFFFF: address decoded as the memory-mapped I/O word.
REQ-003 Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 Addr  input  16  word address from the CPU MAR.
REQ-006 Data_from_CPU  input  16  write data from the CPU MDR.
REQ-007 Mem_CE, Mem_OE, Mem_WE  input  1 each  active-low chip enable, read strobe and write strobe from the CPU controller.
REQ-008 Mem_UB, Mem_LB  input  1 each  active-low byte-lane enables, upper [15:8] and lower [7:0].
REQ-009 Switches  input  16  value returned for reads of IO_ADDR.
REQ-010 Data_to_CPU  output  16  registered read data.
REQ-011 HEX_out  output  16  register written by CPU writes to IO_ADDR.
REQ-012 Busy  output  1  high in any state other than IDLE.
REQ-013 Err  output  1  sticky protocol-error flag.
REQ-014 Acc_count  output  16  count of committed reads plus committed writes; saturates at 16'hFFFF.

Function
REQ-015 FSM states SHALL be IDLE, RD, WR1, WR_DONE.
- Read request: CE=0, OE=0, WE=1.
- Write request: CE=0, WE=0, OE=1.
REQ-016 IDLE: a read request SHALL go to RD; a write request SHALL go to WR1; anything else SHALL stay in IDLE.
REQ-017 On each edge at which a read request is sampled (IDLE or RD), Data_to_CPU SHALL load the word at Addr.
- Read data is therefore valid in the cycle after the first sampled OE-low cycle, matching a 2-cycle CPU read.
REQ-018 Read data source:
- Addr==IO_ADDR: Switches.
- Otherwise: storage[Addr[ADDR_BITS-1:0]]; upper address bits are ignored (aliasing).
REQ-019 A read SHALL ignore UB/LB and always return all 16 bits.
REQ-020 Acc_count SHALL increment once per read, on the IDLE->RD edge.
REQ-021 RD SHALL return to IDLE when the read request is no longer sampled; Data_to_CPU SHALL hold its last value until the next read.
REQ-022 WR1 with the write request still sampled SHALL commit the write on that edge and go to WR_DONE; exactly one commit per strobe.
REQ-023 Commit target:
- Addr==IO_ADDR: HEX_out.
- Otherwise: storage[Addr[ADDR_BITS-1:0]].
- Only lanes whose enable is 0 are written; UB=LB=1 writes nothing but still counts.
- Acc_count increments.
REQ-024 WR1 without the write request sampled (strobe held under 2 cycles) SHALL write nothing, set Err and return to IDLE.
REQ-025 WR_DONE SHALL stay while WE=0 and return to IDLE on WE=1, with no further writes.
REQ-026 CE=0 with OE=0 and WE=0 together, sampled in any state, SHALL set Err, perform no access and force IDLE.
REQ-027 CE=1 in any state SHALL force IDLE with no access; an uncommitted WR1 aborted this way SHALL also set Err.
REQ-028 Err SHALL clear only on reset.

Reset
REQ-029 While Reset=0, regardless of clock, the block SHALL hold: state=IDLE, Data_to_CPU=0, HEX_out=0, Busy=0, Err=0, Acc_count=0.
REQ-030 Storage contents SHALL NOT be cleared by reset and are undefined after power-up.
REQ-031 Reset asserted mid-write before commit SHALL leave storage and HEX_out unmodified; after release the block SHALL accept a new request on the first clock edge.

Verification
REQ-032 Write then read: write 16'hBEEF to 16'h0012 (WE low 2 cycles, UB=LB=0), then OE low 2 cycles at 16'h0012 -> Data_to_CPU=16'hBEEF in the 2nd OE cycle; Acc_count=2; Err=0.
REQ-033 Byte lane: preload 16'h1234 at 16'h0003; write 16'hABCD with UB=1, LB=0 -> read returns 16'h12CD.
REQ-034 MMIO: Switches=16'h00A5, read 16'hFFFF -> 16'h00A5; write 16'h0042 to 16'hFFFF -> HEX_out=16'h0042 from the cycle after commit; storage[8'hFF] unchanged.
REQ-035 Protocol errors (each preceded by reset):
- WE low for 1 cycle at 16'h0007 -> Err=1, storage[7] unchanged, Acc_count unchanged.
- OE and WE low together -> Err=1, state IDLE.
REQ-036 Reset mid-access: assert Reset in the cycle a write is first sampled (WR1) -> all outputs 0 immediately, target word unchanged; a normal read issued after release completes with 2-cycle timing.
REQ-037 Long strobe and aliasing:
- WE held low 5 cycles -> exactly one commit, Acc_count +1.
- Write at 16'h0112 then read at 16'h0012 -> same data.
